// File: rtl/pio_pkg.sv
// Shared constants for the PIO input block: register addresses and the
// encodings for the EDGE_TYPE and IRQ_MODE parameters.
package pio_pkg;

    localparam logic [1:0] ADDR_DATA    = 2'd0;
    localparam logic [1:0] ADDR_RSVD    = 2'd1;
    localparam logic [1:0] ADDR_IRQMASK = 2'd2;
    localparam logic [1:0] ADDR_EDGECAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    localparam int IRQ_LEVEL = 0;
    localparam int IRQ_EDGE  = 1;

endpackage

// File: rtl/pio_sync_edge.sv
// Synchronises the asynchronous input pins into the clk domain and
// produces a one-cycle pulse per bit for each selected edge type.
module pio_sync_edge
    import pio_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [DATA_WIDTH-1:0] async_i,
    output logic [DATA_WIDTH-1:0] sync_o,
    output logic [DATA_WIDTH-1:0] edge_o
);

    logic [DATA_WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [DATA_WIDTH-1:0] prev_q;
    logic [DATA_WIDTH-1:0] rise;
    logic [DATA_WIDTH-1:0] fall;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q[0] <= async_i;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                sync_q[i] <= sync_q[i-1];
            end
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise   = sync_o & ~prev_q;
    assign fall   = ~sync_o & prev_q;

    always_comb begin
        edge_o = rise;
        case (EDGE_TYPE)
            EDGE_FALL: edge_o = fall;
            EDGE_ANY:  edge_o = rise | fall;
            default:   edge_o = rise;
        endcase
    end

endmodule

// File: rtl/pio_in_edge_irq.sv
// Avalon-MM PIO input with synchroniser, per-bit edge capture (W1C),
// interrupt mask and a single interrupt request line.
module pio_in_edge_irq
    import pio_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE,
    parameter int IRQ_MODE    = IRQ_EDGE
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [1:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [31:0]           readdata,
    output logic                  irq
);

    logic [DATA_WIDTH-1:0] sync_in;
    logic [DATA_WIDTH-1:0] edge_pulse;
    logic [DATA_WIDTH-1:0] irqmask_q, irqmask_d;
    logic [DATA_WIDTH-1:0] edgecap_q, edgecap_d;
    logic [31:0]           readdata_q, readdata_d;
    logic                  wr_en;
    logic                  unused_wdata;

    pio_sync_edge #(
        .DATA_WIDTH (DATA_WIDTH),
        .SYNC_STAGES(SYNC_STAGES),
        .EDGE_TYPE  (EDGE_TYPE)
    ) u_sync_edge (
        .clk    (clk),
        .reset_n(reset_n),
        .async_i(in_port),
        .sync_o (sync_in),
        .edge_o (edge_pulse)
    );

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    // New edges are OR-ed in after the W1C clear so a coincident set wins.
    always_comb begin
        irqmask_d = irqmask_q;
        edgecap_d = edgecap_q;
        if (wr_en && address == ADDR_IRQMASK) begin
            irqmask_d = writedata[DATA_WIDTH-1:0];
        end
        if (wr_en && address == ADDR_EDGECAP) begin
            edgecap_d = edgecap_q & ~writedata[DATA_WIDTH-1:0];
        end
        edgecap_d = edgecap_d | edge_pulse;
    end

    always_comb begin
        readdata_d = '0;
        case (address)
            ADDR_DATA:    readdata_d[DATA_WIDTH-1:0] = sync_in;
            ADDR_IRQMASK: readdata_d[DATA_WIDTH-1:0] = irqmask_q;
            ADDR_EDGECAP: readdata_d[DATA_WIDTH-1:0] = edgecap_q;
            default:      readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            irqmask_q  <= '0;
            edgecap_q  <= '0;
            readdata_q <= '0;
        end else begin
            irqmask_q  <= irqmask_d;
            edgecap_q  <= edgecap_d;
            readdata_q <= readdata_d;
        end
    end

    always_comb begin
        if (IRQ_MODE == IRQ_LEVEL) begin
            irq = |(sync_in & irqmask_q);
        end else begin
            irq = |(edgecap_q & irqmask_q);
        end
    end

    assign readdata = readdata_q;

endmodule

// File: tb/tb_pio_in_edge_irq.sv
// Directed bench for pio_in_edge_irq: four instances cover rising, falling
// and any-edge capture plus 32-bit level-mode interrupts.
module tb_pio_in_edge_irq;

    logic        clk;
    logic        reset_n;
    logic [1:0]  address;
    logic        write_n;
    logic [31:0] writedata;
    logic [3:0]  cs;
    logic [15:0] in0, in1, in2;
    logic [31:0] in3;
    logic [31:0] rd0, rd1, rd2, rd3;
    logic [3:0]  irqs;

    int checkCount = 0;
    int errorCount = 0;

    pio_in_edge_irq #(.DATA_WIDTH(16), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(1)) dut0 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[0]),
        .write_n(write_n), .writedata(writedata), .in_port(in0),
        .readdata(rd0), .irq(irqs[0]));

    pio_in_edge_irq #(.DATA_WIDTH(16), .SYNC_STAGES(2), .EDGE_TYPE(1), .IRQ_MODE(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[1]),
        .write_n(write_n), .writedata(writedata), .in_port(in1),
        .readdata(rd1), .irq(irqs[1]));

    pio_in_edge_irq #(.DATA_WIDTH(16), .SYNC_STAGES(2), .EDGE_TYPE(2), .IRQ_MODE(1)) dut2 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[2]),
        .write_n(write_n), .writedata(writedata), .in_port(in2),
        .readdata(rd2), .irq(irqs[2]));

    pio_in_edge_irq #(.DATA_WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_MODE(0)) dut3 (
        .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs[3]),
        .write_n(write_n), .writedata(writedata), .in_port(in3),
        .readdata(rd3), .irq(irqs[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // All driving and sampling happens 1 time unit after the rising edge.
    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] sel, input logic [1:0] addr,
                                 input logic [31:0] data);
        cs        = sel;
        write_n   = 1'b0;
        address   = addr;
        writedata = data;
        tick();
        cs        = 4'b0000;
        write_n   = 1'b1;
        writedata = '0;
    endtask

    task automatic readReg(input logic [1:0] addr);
        address = addr;
        tick();
    endtask

    initial begin
        reset_n   = 1'b0;
        address   = 2'd0;
        write_n   = 1'b1;
        writedata = '0;
        cs        = 4'b0000;
        in0 = '0; in1 = '0; in2 = '0; in3 = '0;
        tick(2);
        reset_n = 1'b1;
        checkOutput("reset_rd0", rd0, 32'h0);
        checkOutput("reset_rd3", rd3, 32'h0);
        checkOutput("reset_irq", {28'h0, irqs}, 32'h0);

        // Data latency: sampled at the next edge, readable two edges later
        in0 = 16'hA5C3;
        tick();
        checkOutput("data_lat_n", rd0, 32'h0);
        tick();
        checkOutput("data_lat_n1", rd0, 32'h0);
        tick();
        checkOutput("data_lat_n2", rd0, 32'h0000A5C3);
        in0 = '0;
        tick(3);
        readReg(2'd3);
        checkOutput("edgecap_a5c3", rd0, 32'h0000A5C3);
        applyStimulus(4'b0001, 2'd3, 32'hFFFF_FFFF);
        readReg(2'd3);
        checkOutput("edgecap_clr_all", rd0, 32'h0);

        // Rising-edge capture and W1C
        applyStimulus(4'b0001, 2'd2, 32'h0000_0001);
        checkOutput("irq_mask_only", {31'h0, irqs[0]}, 32'h0);
        in0[0] = 1'b1;
        tick();
        in0[0] = 1'b0;
        tick(3);
        readReg(2'd3);
        checkOutput("cap_bit0", rd0, 32'h1);
        checkOutput("irq_bit0", {31'h0, irqs[0]}, 32'h1);
        in0[1] = 1'b1;
        tick();
        in0[1] = 1'b0;
        tick(3);
        readReg(2'd3);
        checkOutput("cap_bit01", rd0, 32'h3);
        checkOutput("irq_still", {31'h0, irqs[0]}, 32'h1);
        applyStimulus(4'b0001, 2'd3, 32'h0000_0001);
        checkOutput("irq_cleared", {31'h0, irqs[0]}, 32'h0);
        readReg(2'd3);
        checkOutput("cap_after_w1c", rd0, 32'h2);

        // Capture of bit 4 lands on the same edge as its W1C write
        in0[4] = 1'b1;
        tick(2);
        applyStimulus(4'b0001, 2'd3, 32'h0000_0010);
        readReg(2'd3);
        checkOutput("collision_set_wins", rd0, 32'h12);
        applyStimulus(4'b0001, 2'd3, 32'h0000_0010);
        readReg(2'd3);
        checkOutput("clear_bit4", rd0, 32'h02);

        // Falling-only and any-edge instances get identical stimulus
        in1[7] = 1'b1;
        in2[7] = 1'b1;
        tick(4);
        readReg(2'd3);
        checkOutput("fall_after_rise", rd1, 32'h0);
        checkOutput("any_after_rise", rd2, 32'h80);
        applyStimulus(4'b0100, 2'd3, 32'h0000_0080);
        readReg(2'd3);
        checkOutput("any_cleared", rd2, 32'h0);
        in1[7] = 1'b0;
        in2[7] = 1'b0;
        tick(4);
        readReg(2'd3);
        checkOutput("fall_after_fall", rd1, 32'h80);
        checkOutput("any_after_fall", rd2, 32'h80);

        // Level mode on the 32-bit instance, reserved address held
        applyStimulus(4'b1000, 2'd2, 32'h8000_0000);
        address = 2'd1;
        tick();
        in3[31] = 1'b1;
        tick();
        checkOutput("lvl_irq_n", {31'h0, irqs[3]}, 32'h0);
        checkOutput("rsvd_rd3_a", rd3, 32'h0);
        tick();
        checkOutput("lvl_irq_n1", {31'h0, irqs[3]}, 32'h1);
        checkOutput("rsvd_rd3_b", rd3, 32'h0);
        checkOutput("rsvd_rd0", rd0, 32'h0);
        in3[31] = 1'b0;
        tick();
        checkOutput("lvl_irq_hold", {31'h0, irqs[3]}, 32'h1);
        tick();
        checkOutput("lvl_irq_drop", {31'h0, irqs[3]}, 32'h0);
        readReg(2'd2);
        checkOutput("mask32_rd", rd3, 32'h8000_0000);

        // Mid-operation reset with a concurrent write to DATA
        in0 = '0;
        tick(3);
        in0 = 16'hFFFF;
        tick(4);
        applyStimulus(4'b0001, 2'd2, 32'h0000_FFFF);
        checkOutput("pre_rst_irq", {31'h0, irqs[0]}, 32'h1);
        readReg(2'd3);
        checkOutput("pre_rst_cap", rd0, 32'h0000_FFFF);
        in0       = '0;
        reset_n   = 1'b0;
        cs        = 4'b0001;
        write_n   = 1'b0;
        address   = 2'd0;
        writedata = 32'h0000_FFFF;
        tick();
        checkOutput("rst_irq", {31'h0, irqs[0]}, 32'h0);
        checkOutput("rst_rd", rd0, 32'h0);
        reset_n = 1'b1;
        cs      = 4'b0000;
        write_n = 1'b1;
        readReg(2'd3);
        checkOutput("rst_cap", rd0, 32'h0);
        readReg(2'd2);
        checkOutput("rst_mask", rd0, 32'h0);
        applyStimulus(4'b0001, 2'd0, 32'h0000_FFFF);
        readReg(2'd0);
        checkOutput("data_write_ignored", rd0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/pio_in_edge_irq.md
Name: pio_in_edge_irq

Overview:
- Parametrised successor to the MCU's 16-bit read-only PIO input: Avalon-MM slave on the system bus with configurable width.
- Adds a metastability synchroniser on in_port, per-bit edge capture with write-1-to-clear, an interrupt mask register and an irq output to the Nios interrupt controller.
- Registered readdata; one-cycle read latency.

Parameters:
- DATA_WIDTH, 16, number of input bits, 1..32
- SYNC_STAGES, 2, synchroniser flops per bit, 2..4
- EDGE_TYPE, 0, edges captured: 0 = rising, 1 = falling, 2 = any
- IRQ_MODE, 1, interrupt source: 0 = level of masked synchronised inputs, 1 = masked edge-capture bits

Ports:
- clk  input  1  system clock; the only clock
- reset_n  input  1  synchronous active-low reset
- address  input  2  word register select
- chipselect  input  1  slave select
- write_n  input  1  active-low write strobe
- writedata  input  32  write data
- in_port  input  DATA_WIDTH  asynchronous external inputs
- readdata  output  32  registered read data
- irq  output  1  interrupt request, active high

Behaviour:
- Reset: reset_n is sampled on the rising clk edge. It clears all of the following to 0: synchroniser chain, prev register, edgecapture, irqmask and readdata. irq is therefore 0.
- Sync: in_port passes through SYNC_STAGES flops to give sync_q. prev_q is sync_q delayed by one clock.
- Edge detect (per bit): rise = sync_q & ~prev_q; fall = ~sync_q & prev_q. EDGE_TYPE selects rise, fall or rise|fall.
- Register map (32-bit words; bits above DATA_WIDTH read 0):
  - 0 DATA: read sync_q; writes ignored.
  - 1 reserved: reads 0; writes ignored.
  - 2 IRQMASK: read/write; stores writedata[DATA_WIDTH-1:0].
  - 3 EDGECAP: read edgecapture; write-1-to-clear: edgecapture <= edgecapture & ~writedata bits.
- Write occurs when chipselect=1 and write_n=0 at a clk edge.
- readdata: updated every clock from the address mux regardless of chipselect, matching the existing PIO. Data is valid on the edge after address is presented.
- Edge capture: a detected edge sets its bit on the next clock edge. The bit stays set until cleared by a write.
- Simultaneous edge and W1C clear on the same bit in the same cycle: set wins and the bit stays 1.
- Latency: an in_port change sampled at edge N appears in sync_q at edge N+SYNC_STAGES-1. edgecapture and DATA readdata update at edge N+SYNC_STAGES.
- irq is combinational from registers only (no in_port path):
  - IRQ_MODE=0: OR of (sync_q & irqmask)
  - IRQ_MODE=1: OR of (edgecapture & irqmask)
- Post-reset artefact: an input held high through reset produces a rise on prev/sync after release. It is captured as an edge when EDGE_TYPE is 0 or 2. This is accepted; software clears EDGECAP at init.
- Reset asserted mid-operation: all state is cleared on that edge, including pending edges. irq falls the same cycle the registers clear.

Decomposition:
- Shared package pio_pkg holds:
  - address constants ADDR_DATA=0, ADDR_IRQMASK=2, ADDR_EDGECAP=3
  - EDGE_RISE/EDGE_FALL/EDGE_ANY encodings
  - IRQ_LEVEL/IRQ_EDGE encodings
- One sub-module, pio_sync_edge:
  - parametrised on DATA_WIDTH, SYNC_STAGES and EDGE_TYPE
  - outputs sync_q and an edge pulse vector
- Top level holds the register file, read mux and irq logic.

Test Plan (DATA_WIDTH=16, SYNC_STAGES=2 unless stated):
- Reset / data latency: assert reset_n=0 for 2 clocks, then release. Expect readdata=0 and irq=0. Drive in_port=16'hA5C3 with address=0 held. Expect readdata=32'h0000A5C3 exactly 2 clocks after the sampling edge, and 0 before that.
- Rising-edge capture / clear (EDGE_TYPE=0, IRQ_MODE=1):
  - Write IRQMASK=16'h0001.
  - Pulse in_port[0] high 1 clock, then low. Expect EDGECAP read=1 and irq=1.
  - Pulse in_port[1]. Expect EDGECAP=3 and irq still 1.
  - Write EDGECAP=32'h1. Expect EDGECAP=2 and irq=0.
- Set-vs-clear collision: time the in_port[4] rise so its capture coincides with a write EDGECAP=32'h10. Expect bit 4 to remain 1.
- Falling / any edge:
  - EDGE_TYPE=1: toggle in_port[7] 0->1->0. Expect exactly one capture, on the fall.
  - EDGE_TYPE=2: the same stimulus sets the bit after the rise; clear it, and the fall sets it again.
- Level mode and width (IRQ_MODE=0, DATA_WIDTH=32): write IRQMASK=32'h8000_0000, drive in_port[31]=1. Expect irq=1 two clocks later; it drops to 0 two clocks after in_port[31]=0. Read address 1 returns 0 throughout.
- Mid-operation reset: set EDGECAP=16'hFFFF and IRQMASK=16'hFFFF so irq=1. Pulse reset_n low for 1 clock. Expect EDGECAP=0, IRQMASK=0 and irq=0 on that edge; a write to address 0 has no effect.
